// File: rtl/jt89_vol_ramp.sv
// jt89_vol_ramp: per-channel attenuator with click-free stepped volume ramps
// and a registered sum of all channel amplitudes.
module jt89_vol_ramp #(
  parameter int unsigned CH   = 4,
  parameter int unsigned W    = 9,
  parameter int unsigned RAMP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [CH-1:0]     din,
  input  logic [4*CH-1:0]   vol,
  output logic [W*CH-1:0]   snd,
  output logic [W+2:0]      mix,
  output logic [CH-1:0]     busy
);

  localparam int unsigned MW  = W + 3;
  localparam int unsigned RCW = 8;

  logic [CH-1:0][3:0]     cur;
  logic [CH-1:0][3:0]     cur_nxt;
  logic [CH-1:0][RCW-1:0] rcnt;
  logic [CH-1:0][RCW-1:0] rcnt_nxt;
  logic [W*CH-1:0]        snd_nxt;
  logic [MW-1:0]          mix_nxt;

  // 2 dB/step amplitude; code 0 is forced to full scale at any width
  function automatic logic [W-1:0] amp(input logic [3:0] code);
    logic [8:0] base;
    case (code)
      4'd0:    base = 9'd511;
      4'd1:    base = 9'd406;
      4'd2:    base = 9'd322;
      4'd3:    base = 9'd256;
      4'd4:    base = 9'd203;
      4'd5:    base = 9'd161;
      4'd6:    base = 9'd128;
      4'd7:    base = 9'd102;
      4'd8:    base = 9'd81;
      4'd9:    base = 9'd64;
      4'd10:   base = 9'd51;
      4'd11:   base = 9'd40;
      4'd12:   base = 9'd32;
      4'd13:   base = 9'd26;
      4'd14:   base = 9'd20;
      default: base = 9'd0;
    endcase
    if (code == 4'd0) amp = '1;
    else              amp = W'(base) << (W - 9);
  endfunction

  // Ramp step: the direction is re-evaluated every tick, rcnt only clears
  // at terminal count or when the target is reached
  always_comb begin
    cur_nxt  = cur;
    rcnt_nxt = rcnt;
    for (int k = 0; k < int'(CH); k++) begin
      if (cur[k] == vol[4*k +: 4]) begin
        rcnt_nxt[k] = '0;
      end else if (rcnt[k] == RCW'(RAMP - 1)) begin
        rcnt_nxt[k] = '0;
        if (vol[4*k +: 4] < cur[k]) cur_nxt[k] = cur[k] - 4'd1;
        else                        cur_nxt[k] = cur[k] + 4'd1;
      end else begin
        rcnt_nxt[k] = rcnt[k] + RCW'(1);
      end
    end
  end

  // Channel amplitude from the pre-update code, and the mix from current snd
  always_comb begin
    snd_nxt = '0;
    mix_nxt = '0;
    for (int k = 0; k < int'(CH); k++) begin
      snd_nxt[W*k +: W] = din[k] ? amp(cur[k]) : '0;
      mix_nxt = mix_nxt + MW'(snd[W*k +: W]);
    end
  end

  // State and output registers; everything holds while clk_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(CH); k++) begin
        cur[k]  <= 4'd15;
        rcnt[k] <= '0;
      end
      snd <= '0;
      mix <= '0;
    end else if (clk_en) begin
      cur  <= cur_nxt;
      rcnt <= rcnt_nxt;
      snd  <= snd_nxt;
      mix  <= mix_nxt;
    end
  end

  // Channel still ramping toward its target
  always_comb begin
    busy = '0;
    for (int k = 0; k < int'(CH); k++) begin
      busy[k] = (cur[k] != vol[4*k +: 4]);
    end
  end

endmodule
